// File: rtl/ex01_vector_sequencer.sv
// Clocked stimulus sequencer: sweeps {a,b,c} through all 8 vectors and records P/Q truth tables.
// Optional macro GRAY_ORDER_EN selects Gray-code sweep order (one input toggles per step).
module ex01_vector_sequencer #(
    parameter int HOLD_CYCLES = 20,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       p_in,
    input  logic       q_in,
    output logic [2:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_p,
    output logic [7:0] table_q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           r_state;
    logic [2:0]       r_step;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_vec;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       r_tp;
    logic [7:0]       r_tq;

    // Step number to driven vector; tables are always indexed by the vector value itself.
    function automatic logic [2:0] step_to_vec(input logic [2:0] s);
`ifdef GRAY_ORDER_EN
        return s ^ (s >> 1);
`else
        return s;
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_step  <= 3'd0;
            r_cnt   <= '0;
            r_vec   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tp    <= 8'd0;
            r_tq    <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_vec  <= 3'd0;
                    if (start) begin
                        r_state <= S_DRIVE;
                        r_step  <= 3'd0;
                        r_cnt   <= '0;
                        r_tp    <= 8'd0;
                        r_tq    <= 8'd0;
                        r_busy  <= 1'b1;
                        r_vec   <= step_to_vec(3'd0);
                    end
                end
                S_DRIVE: begin
                    // Pause freezes everything, including a sample that would land on this edge.
                    if (!pause) begin
                        if (r_cnt == CNT_LAST) begin
                            r_tp[r_vec] <= p_in;
                            r_tq[r_vec] <= q_in;
                            r_cnt       <= '0;
                            if (r_step != 3'd7) begin
                                r_step <= r_step + 3'd1;
                                r_vec  <= step_to_vec(r_step + 3'd1);
                            end else begin
                                r_state <= S_DONE;
                                r_vec   <= 3'd0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign a       = r_vec[2];
    assign b       = r_vec[1];
    assign c       = r_vec[0];
    assign vec_idx = r_vec;
    assign busy    = r_busy;
    assign done    = r_done;
    assign table_p = r_tp;
    assign table_q = r_tq;

endmodule

// File: tb/tb_ex01_vector_sequencer.sv
// Bench for ex01_vector_sequencer: two instances (hold 20 and hold 1) with loopback P=a^b^c, Q=a&b.
module tb_ex01_vector_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, pause0 = 1'b0, start1 = 1'b0, pause1 = 1'b0;
    logic a0, b0, c0, a1, b1, c1;
    logic p0, q0, p1, q1;
    logic [2:0] vec0, vec1;
    logic busy0, done0, busy1, done1;
    logic [7:0] tp0, tq0, tp1, tq1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign p0 = a0 ^ b0 ^ c0;
    assign q0 = a0 & b0;
    assign p1 = a1 ^ b1 ^ c1;
    assign q1 = a1 & b1;

    ex01_vector_sequencer #(.HOLD_CYCLES(20), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .pause(pause0),
        .a(a0), .b(b0), .c(c0), .p_in(p0), .q_in(q0),
        .vec_idx(vec0), .busy(busy0), .done(done0), .table_p(tp0), .table_q(tq0)
    );

    ex01_vector_sequencer #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .pause(pause1),
        .a(a1), .b(b1), .c(c1), .p_in(p1), .q_in(q1),
        .vec_idx(vec1), .busy(busy1), .done(done1), .table_p(tp1), .table_q(tq1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Sweep order as a plain lookup table.
    function automatic logic [2:0] ord(input int s);
        logic [2:0] t [8];
`ifdef GRAY_ORDER_EN
        t = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`else
        t = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
        return t[s];
    endfunction

    // Expected tables after 'comp' completed steps of the loopback sweep.
    function automatic logic [7:0] exp_tp(input int comp);
        logic [7:0] r = 8'd0;
        logic [2:0] v;
        for (int s = 0; s < comp && s < 8; s++) begin
            v = ord(s);
            r[v] = ^v;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_tq(input int comp);
        logic [7:0] r = 8'd0;
        logic [2:0] v;
        for (int s = 0; s < comp && s < 8; s++) begin
            v = ord(s);
            r[v] = v[2] & v[1];
        end
        return r;
    endfunction

    // Model: 0=idle 1=sweeping 2=done; m_k counts unpaused sweep cycles, m_comp completed steps.
    int H [2] = '{20, 1};
    int m_state [2];
    int m_k [2];
    int m_comp [2];

    always @(posedge clk or negedge rst_n) begin
        int nk;
        logic s, p;
        if (!rst_n) begin
            for (int j = 0; j < 2; j++) begin
                m_state[j] <= 0;
                m_k[j]     <= 0;
                m_comp[j]  <= 0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                s = (j == 0) ? start0 : start1;
                p = (j == 0) ? pause0 : pause1;
                case (m_state[j])
                    0: if (s) begin
                        m_state[j] <= 1;
                        m_k[j]     <= 0;
                        m_comp[j]  <= 0;
                    end
                    1: if (!p) begin
                        nk = m_k[j] + 1;
                        m_k[j]    <= nk;
                        m_comp[j] <= nk / H[j];
                        if (nk == 8 * H[j]) m_state[j] <= 2;
                    end
                    default: m_state[j] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0] ev;
        if (rst_n) begin
            for (int j = 0; j < 2; j++) begin
                ev = (m_state[j] == 1) ? ord(m_k[j] / H[j]) : 3'd0;
                chk($sformatf("vec%0d", j), (j == 0) ? vec0 : vec1, ev);
                chk($sformatf("abc%0d", j), (j == 0) ? {a0, b0, c0} : {a1, b1, c1}, ev);
                chk($sformatf("busy%0d", j), (j == 0) ? busy0 : busy1, m_state[j] == 1);
                chk($sformatf("done%0d", j), (j == 0) ? done0 : done1, m_state[j] == 2);
                chk($sformatf("table_p%0d", j), (j == 0) ? tp0 : tp1, exp_tp(m_comp[j]));
                chk($sformatf("table_q%0d", j), (j == 0) ? tq0 : tq1, exp_tq(m_comp[j]));
            end
        end
    end

    // Waits (bounded) for done0 and returns cycles since t0, or -1 on timeout.
    task automatic wait_done0(input int t0, output int n);
        n = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done0) begin
                n = cyc - t0;
                break;
            end
        end
    endtask

    task automatic pulse_start0(output int t0);
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        t0 = cyc;
    endtask

    initial begin
        int t0, n, cnt;
        logic [2:0] seq [8];

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state", {a0, b0, c0, vec0, busy0, done0, tp0, tq0}, 0);

        // Full sweep with hold 20
        pulse_start0(t0);
        chk("first_vec_busy", {busy0, vec0}, {1'b1, 3'd0});
        wait_done0(t0, n);
        chk("done_latency", n, 160);
        chk("tp_full", tp0, 8'b1001_0110);
        chk("tq_full", tq0, 8'b1100_0000);
        @(negedge clk);
        chk("done_one_cycle", done0, 1'b0);

        // Second start clears tables; a re-pulse while busy is ignored
        pulse_start0(t0);
        chk("tables_cleared", {tp0, tq0}, 16'h0000);
        repeat (30) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        wait_done0(t0, n);
        chk("done_latency_restart", n, 160);
        chk("tp_rebuilt", tp0, 8'h96);
        chk("tq_rebuilt", tq0, 8'hC0);
        repeat (3) @(negedge clk);
        chk("no_second_done", {done0, busy0}, 2'b00);

        // Pause for 5 cycles during vector 2
        pulse_start0(t0);
        repeat (45) @(negedge clk);
        chk("vec_before_pause", vec0, ord(2));
        pause0 = 1'b1;
        repeat (5) @(negedge clk);
        pause0 = 1'b0;
        wait_done0(t0, n);
        chk("done_latency_pause", n, 165);
        chk("tables_pause", {tp0, tq0}, 16'h96C0);
        repeat (2) @(negedge clk);

        // Reset mid-sweep at vector 3
        pulse_start0(t0);
        repeat (65) @(negedge clk);
        chk("vec_before_reset", vec0, ord(3));
        chk("partial_tp", tp0, exp_tp(3));
        #2 rst_n = 1'b0;
        #1 chk("reset_midsweep", {a0, b0, c0, vec0, busy0, done0, tp0, tq0}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_done_after_reset", {done0, busy0, tp0}, 0);

        // Hold of 1: new vector every cycle
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        t0 = cyc;
        cnt = 0;
        n = -1;
        seq[0] = {a1, b1, c1};
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done1) begin
                n = cyc - t0;
                break;
            end
            if (busy1 && cnt < 8) begin
                seq[cnt] = {a1, b1, c1};
                cnt++;
            end
        end
        chk("hold1_done_latency", n, 8);
        chk("hold1_vectors", cnt, 8);
        chk("hold1_tables", {tp1, tq1}, 16'h96C0);
`ifdef GRAY_ORDER_EN
        chk("gray_seq", {seq[0], seq[1], seq[2], seq[3], seq[4], seq[5], seq[6], seq[7]},
            {3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100});
        for (int i = 1; i < 8; i++)
            chk($sformatf("gray_onebit%0d", i), $countones(seq[i] ^ seq[i-1]), 1);
`else
        chk("binary_seq", {seq[0], seq[1], seq[2], seq[3], seq[4], seq[5], seq[6], seq[7]},
            {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7});
`endif
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
